sort_stream_oet: RTL and testbench
==================================

// Module: sort_stream_oet
// PURPOSE
//  Streaming frame sorter: accepts NUM_ELEM words over a valid/ready input,
//  sorts them in place with an odd-even transposition network (one phase per
//  cycle), then streams the sorted frame out over a valid/ready output.
//  Successor to the fixed-direction sorter: direction is selected per frame and
//  signed/unsigned compare is a parameter. Sits between the data source and the
//  consumer in the sort datapath.
// PARAMETERS
//  NUM_ELEM   8  elements per frame; legal values >= 2 (odd values allowed)
//  SIZE_DATA  8  bits per element
//  SIGNED     0  1 = two's-complement compare, 0 = unsigned compare
// PORTS
//  i_clk     in   1          clock, all logic on the rising edge
//  i_reset   in   1          synchronous reset, active-high
//  i_asc     in   1          direction: 1 = ascending, 0 = descending; sampled with 1st element
//  i_valid   in   1          input element valid
//  o_ready   out  1          sorter accepts an input element
//  i_data    in   SIZE_DATA  input element
//  o_valid   out  1          output element valid
//  i_ready   in   1          consumer accepts an output element
//  o_data    out  SIZE_DATA  output element, sorted order
//  o_last    out  1          high with the final element of the frame
//  o_busy    out  1          high in SORT or OUT
// BEHAVIOUR
//  Reset: state=LOAD, counters=0, o_ready=1, o_valid=0, o_last=0, o_busy=0,
//   o_data=0, element array cleared. Reset mid-frame discards the frame.
//  FSM: LOAD -> SORT -> OUT -> LOAD. All outputs registered or decoded from state only.
//  LOAD: o_ready=1. Handshake = i_valid & o_ready; each handshake writes
//   mem[idx], idx++. On the 1st handshake, latch i_asc into dir_q. On the
//   NUM_ELEM-th handshake -> SORT, idx=0. i_asc is ignored on later elements.
//  SORT: o_ready=0; exactly NUM_ELEM cycles, phase p=0..NUM_ELEM-1.
//   Even p: compare-swap pairs (0,1),(2,3)..; odd p: (1,2),(3,4)..
//   Unpaired end element holds. Swap only on strict out-of-order
//   (ascending: a>b, descending: a<b); equal pair never swaps.
//   After phase NUM_ELEM-1 -> OUT.
//  OUT: o_valid=1, o_data=mem[idx], o_last=(idx==NUM_ELEM-1).
//   Output handshake = o_valid & i_ready advances idx. While i_ready=0,
//   o_data and o_last stay stable. After the handshake with o_last=1 ->
//   LOAD; o_ready=1 on the next cycle.
//  Latency: the first o_valid comes NUM_ELEM+1 cycles after the edge that
//   accepts the last input element.
//  Frame period at full throughput: 3*NUM_ELEM+1 cycles.
//  No input overlap: i_valid is ignored in SORT/OUT; the producer holds its data.
//  Widths: idx = $clog2(NUM_ELEM) bits, phase counter = $clog2(NUM_ELEM+1) bits.
//   Compare casts to signed when SIGNED=1.
// STRUCTURE
//  Package P_SORT:
//   - typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_OUT} sort_state_e
//   - function f_out_of_order(a, b, asc, sgn)
//  Sub-module sort_cas (combinational compare-and-swap cell):
//   - ports: a, b, asc, en -> lo/hi ordered pair
//   - generate NUM_ELEM/2 instances; the even/odd phase steers operand pairing
// TESTING
//  1 asc, SIGNED=0: load 5,3,8,1,9,2,7,4, i_ready=1 -> 1,2,3,4,5,7,8,9;
//    o_last on 9; first o_valid 9 cycles after the last input edge
//  2 desc, dups: load 4,4,1,7,1,7,0,255 -> 255,7,7,4,4,1,1,0; o_last only on 0
//  3 SIGNED=1 asc: 8'h80,8'h7F,0,8'hFF,1,8'h80,2,3
//    -> 80,80,FF,00,01,02,03,7F
//  4 i_ready toggled randomly (50%): o_data/o_last stable while stalled;
//    exact 8-element order; o_ready=0 until after last handshake
//  5 i_asc=1 on 1st element, 0 on the rest -> frame sorted ascending;
//    NUM_ELEM=5 frame 3,1,2,5,4 -> 1..5
//  6 i_reset=1 for one cycle during SORT phase 3 -> next cycle: o_ready=1,
//    o_valid=0, o_busy=0; new frame sorts correctly with no stale data

Source files
------------

// File: rtl/P_SORT.sv
// Shared types and compare helper for the streaming odd-even transposition sorter.
package P_SORT;

    // Widest element the compare helper handles; callers extend operands to this width.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_OUT} sort_state_e;

    // True when (a, b) must be swapped for the requested direction.
    // Strictly out of order only, so equal operands never swap.
    function automatic logic f_out_of_order(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b,
                                            input logic             asc,
                                            input logic             sgn);
        logic gt;
        logic lt;
        if (sgn) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return asc ? gt : lt;
    endfunction

endpackage

// File: rtl/sort_cas.sv
// Combinational compare-and-swap cell: lo goes to the lower index, hi to the upper.
module sort_cas
    import P_SORT::*;
#(
    parameter int SIZE_DATA = 8,
    parameter int SIGNED    = 0
) (
    input  logic [SIZE_DATA-1:0] a,
    input  logic [SIZE_DATA-1:0] b,
    input  logic                 asc,
    input  logic                 en,
    output logic [SIZE_DATA-1:0] lo,
    output logic [SIZE_DATA-1:0] hi
);

    logic [MAX_W-1:0] ax;
    logic [MAX_W-1:0] bx;
    logic             swap;

    // Extend operands to the helper width (sign- or zero-extend) and order the pair.
    always_comb begin
        if (SIGNED != 0) begin
            ax = MAX_W'($signed(a));
            bx = MAX_W'($signed(b));
        end else begin
            ax = MAX_W'(a);
            bx = MAX_W'(b);
        end
        swap = en && f_out_of_order(ax, bx, asc, SIGNED != 0);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/sort_stream_oet.sv
// Streaming frame sorter: load NUM_ELEM words, run NUM_ELEM odd-even
// transposition phases in place, then stream the frame out through a
// registered output stage.
module sort_stream_oet
    import P_SORT::*;
#(
    parameter int NUM_ELEM  = 8,
    parameter int SIZE_DATA = 8,
    parameter int SIGNED    = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_asc,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data,
    output logic                 o_last,
    output logic                 o_busy
);

    localparam int IDX_W = $clog2(NUM_ELEM);
    localparam int PH_W  = $clog2(NUM_ELEM + 1);
    localparam int NPAIR = NUM_ELEM / 2;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEM - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(NUM_ELEM - 1);

    sort_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             dir_q, dir_d;
    logic [NUM_ELEM-1:0][SIZE_DATA-1:0] mem_q, mem_d;
    logic                 out_vld_q, out_vld_d;
    logic [SIZE_DATA-1:0] out_data_q, out_data_d;
    logic                 out_last_q, out_last_d;

    logic                             phase_even;
    logic [NPAIR-1:0][SIZE_DATA-1:0]  cas_lo;
    logic [NPAIR-1:0][SIZE_DATA-1:0]  cas_hi;
    logic [NPAIR-1:0]                 cas_en;

    assign phase_even = ~phase_q[0];

    // Pair k compares (2k,2k+1) on even phases and (2k+1,2k+2) on odd phases.
    // The last pair has no odd-phase partner when NUM_ELEM is even, so it idles then.
    for (genvar k = 0; k < NPAIR; k++) begin : g_cas
        logic [SIZE_DATA-1:0] op_a;
        logic [SIZE_DATA-1:0] op_b;
        logic                 op_en;
        if (2 * k + 2 < NUM_ELEM) begin : g_mid
            assign op_a  = phase_even ? mem_q[2*k]   : mem_q[2*k+1];
            assign op_b  = phase_even ? mem_q[2*k+1] : mem_q[2*k+2];
            assign op_en = 1'b1;
        end else begin : g_end
            assign op_a  = mem_q[2*k];
            assign op_b  = mem_q[2*k+1];
            assign op_en = phase_even;
        end
        assign cas_en[k] = op_en;
        sort_cas #(
            .SIZE_DATA (SIZE_DATA),
            .SIGNED    (SIGNED)
        ) u_cas (
            .a   (op_a),
            .b   (op_b),
            .asc (dir_q),
            .en  (op_en),
            .lo  (cas_lo[k]),
            .hi  (cas_hi[k])
        );
    end

    // Handshake outputs are decoded from state; data/last come from the output register.
    assign o_ready = (state_q == ST_LOAD);
    assign o_busy  = (state_q != ST_LOAD);
    assign o_valid = out_vld_q;
    assign o_data  = out_data_q;
    assign o_last  = out_last_q;

    // Next-state logic: load, sort phases, then drain through the output register.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        phase_d    = phase_q;
        dir_d      = dir_q;
        mem_d      = mem_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        case (state_q)
            ST_LOAD: begin
                if (i_valid) begin
                    mem_d[idx_q] = i_data;
                    if (idx_q == '0) dir_d = i_asc;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        phase_d = '0;
                        state_d = ST_SORT;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SORT: begin
                for (int k = 0; k < NPAIR; k++) begin
                    int j;
                    j = 2 * k + (phase_even ? 0 : 1);
                    if (cas_en[k]) begin
                        mem_d[j]     = cas_lo[k];
                        mem_d[j + 1] = cas_hi[k];
                    end
                end
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    state_d = ST_OUT;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            ST_OUT: begin
                // Final element accepted: release the frame.
                if (out_vld_q && i_ready && out_last_q) begin
                    out_vld_d  = 1'b0;
                    out_last_d = 1'b0;
                    idx_d      = '0;
                    state_d    = ST_LOAD;
                // Output register empty or being drained: fetch the next element.
                end else if (!out_vld_q || i_ready) begin
                    out_vld_d  = 1'b1;
                    out_data_d = mem_q[idx_q];
                    out_last_d = (idx_q == IDX_LAST);
                    idx_d      = idx_q + IDX_W'(1);
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // State registers with synchronous reset; reset discards any frame in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_LOAD;
            idx_q      <= '0;
            phase_q    <= '0;
            dir_q      <= 1'b0;
            mem_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            phase_q    <= phase_d;
            dir_q      <= dir_d;
            mem_q      <= mem_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
        end
    end

endmodule

// File: tb/tb_sort_stream_oet.sv
// Directed bench for sort_stream_oet: three instances (unsigned N=8,
// signed N=8, unsigned N=5) share stimulus; sel picks the active one.
module tb_sort_stream_oet;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         sel = 0;
    logic       vin = 1'b0;
    logic [7:0] din = '0;
    logic       asc = 1'b1;
    logic       rdy = 1'b0;
    int         cyc = 0;

    logic [2:0] ordy_k, ovld_k, olast_k, obusy_k;
    logic [7:0] odat_k [3];
    logic       ordy, ovld, olast, obusy;
    logic [7:0] odat;

    int errors = 0;
    int checks = 0;

    logic [7:0] vals [8];
    logic [7:0] exps [8];
    int         last_in_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_stream_oet #(.NUM_ELEM(8), .SIZE_DATA(8), .SIGNED(0)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_asc(asc),
        .i_valid(vin && sel == 0), .o_ready(ordy_k[0]), .i_data(din),
        .o_valid(ovld_k[0]), .i_ready(rdy && sel == 0), .o_data(odat_k[0]),
        .o_last(olast_k[0]), .o_busy(obusy_k[0]));

    sort_stream_oet #(.NUM_ELEM(8), .SIZE_DATA(8), .SIGNED(1)) u_sgn (
        .i_clk(clk), .i_reset(rst), .i_asc(asc),
        .i_valid(vin && sel == 1), .o_ready(ordy_k[1]), .i_data(din),
        .o_valid(ovld_k[1]), .i_ready(rdy && sel == 1), .o_data(odat_k[1]),
        .o_last(olast_k[1]), .o_busy(obusy_k[1]));

    sort_stream_oet #(.NUM_ELEM(5), .SIZE_DATA(8), .SIGNED(0)) u_five (
        .i_clk(clk), .i_reset(rst), .i_asc(asc),
        .i_valid(vin && sel == 2), .o_ready(ordy_k[2]), .i_data(din),
        .o_valid(ovld_k[2]), .i_ready(rdy && sel == 2), .o_data(odat_k[2]),
        .o_last(olast_k[2]), .o_busy(obusy_k[2]));

    always_comb begin
        ordy  = ordy_k[sel];
        ovld  = ovld_k[sel];
        olast = olast_k[sel];
        obusy = obusy_k[sel];
        odat  = odat_k[sel];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Feed n elements of vals; i_asc = a0 on the first, a1 on the rest.
    task automatic send(input int n, input logic a0, input logic a1);
        for (int i = 0; i < n; i++) begin
            vin = 1'b1;
            din = vals[i];
            asc = (i == 0) ? a0 : a1;
            if (i == 0) chk("ready_load", {31'b0, ordy}, 32'd1);
            @(posedge clk); #1;
        end
        vin = 1'b0;
        last_in_cyc = cyc;
    endtask

    // Drain n elements, compare against exps, check stall stability and latency.
    task automatic recv(input int n, input bit stall);
        int   got = 0;
        int   spin = 0;
        bit   seen = 0;
        bit   held = 0;
        logic [7:0] hd;
        logic       hl;
        while (got < n && spin < 500) begin
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                chk("stall_data", {24'b0, odat}, {24'b0, hd});
                chk("stall_last", {31'b0, olast}, {31'b0, hl});
            end
            chk("no_ready_out", {31'b0, ordy}, 32'd0);
            if (ovld && !seen) begin
                seen = 1;
                chk("latency", cyc - last_in_cyc, n + 1);
            end
            held = 0;
            if (ovld && rdy) begin
                chk($sformatf("data%0d", got), {24'b0, odat}, {24'b0, exps[got]});
                chk($sformatf("last%0d", got), {31'b0, olast}, {31'b0, got == n - 1});
                got++;
            end else if (ovld) begin
                held = 1;
                hd   = odat;
                hl   = olast;
            end
            @(posedge clk); #1;
            spin++;
        end
        rdy = 1'b0;
        chk("drain_done", got, n);
        chk("post_ready", {31'b0, ordy}, 32'd1);
        chk("post_valid", {31'b0, ovld}, 32'd0);
        chk("post_busy", {31'b0, obusy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_ready", {31'b0, ordy}, 32'd1);
        chk("rst_valid", {31'b0, ovld}, 32'd0);
        chk("rst_last", {31'b0, olast}, 32'd0);
        chk("rst_busy", {31'b0, obusy}, 32'd0);
        chk("rst_data", {24'b0, odat}, 32'd0);

        // 1: ascending unsigned
        sel = 0;
        vals = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
        exps = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
        send(8, 1'b1, 1'b1);
        chk("busy_sort", {31'b0, obusy}, 32'd1);
        recv(8, 0);

        // 2: descending with duplicates
        vals = '{8'd4, 8'd4, 8'd1, 8'd7, 8'd1, 8'd7, 8'd0, 8'd255};
        exps = '{8'd255, 8'd7, 8'd7, 8'd4, 8'd4, 8'd1, 8'd1, 8'd0};
        send(8, 1'b0, 1'b0);
        recv(8, 0);

        // 3: signed ascending
        sel = 1;
        vals = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80, 8'h02, 8'h03};
        exps = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03, 8'h7F};
        send(8, 1'b1, 1'b1);
        recv(8, 0);

        // 4: random output stalls
        sel = 0;
        vals = '{8'd10, 8'd200, 8'd30, 8'd0, 8'd99, 8'd50, 8'd150, 8'd60};
        exps = '{8'd0, 8'd10, 8'd30, 8'd50, 8'd60, 8'd99, 8'd150, 8'd200};
        send(8, 1'b1, 1'b1);
        recv(8, 1);

        // 5: direction latched from the first element only
        vals = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2};
        exps = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send(8, 1'b1, 1'b0);
        recv(8, 0);
        sel = 2;
        vals = '{8'd3, 8'd1, 8'd2, 8'd5, 8'd4, 8'd0, 8'd0, 8'd0};
        exps = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0};
        send(5, 1'b1, 1'b0);
        recv(5, 0);

        // 6: reset during sort phase 3 drops the frame
        sel = 0;
        vals = '{8'd99, 8'd98, 8'd97, 8'd96, 8'd95, 8'd94, 8'd93, 8'd92};
        send(8, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_ready", {31'b0, ordy}, 32'd1);
        chk("mid_rst_valid", {31'b0, ovld}, 32'd0);
        chk("mid_rst_busy", {31'b0, obusy}, 32'd0);
        vals = '{8'd20, 8'd10, 8'd40, 8'd30, 8'd60, 8'd50, 8'd80, 8'd70};
        exps = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        send(8, 1'b1, 1'b1);
        recv(8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
